// File: rtl/uart_frame_parser.sv
// uart_frame_parser: hunts SYNC, parses SYNC|ADDR|LEN|payload|CHK frames from a UART byte
// stream and forwards the payload as AXI4-Stream with tlast/tuser on the final beat.
// Optional good/error counters are built when UART_FRAME_PARSER_STATS_EN is defined.
module uart_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               input_axis_tdata,
  input  logic                     input_axis_tvalid,
  output logic                     input_axis_tready,
  output logic [7:0]               output_axis_tdata,
  output logic                     output_axis_tvalid,
  input  logic                     output_axis_tready,
  output logic                     output_axis_tlast,
  output logic                     output_axis_tuser,
  output logic [7:0]               frame_addr,
  output logic                     frame_good,
  output logic                     frame_bad,
  output logic                     timeout_error,
  output logic                     busy,
  output logic [15:0]              frame_count,
  output logic [15:0]              error_count,
  input  logic [TIMEOUT_WIDTH-1:0] timeout
);

  typedef enum logic [2:0] {StHunt, StAddr, StLen, StPayload, StChk, StFlush} state_e;

  state_e                   r_state, w_state_d;
  logic [7:0]               r_sum, w_sum_d;
  logic [7:0]               r_len, w_len_d;
  logic [7:0]               r_hold_data, w_hold_data_d;
  logic                     r_hold_valid, w_hold_valid_d;
  logic [7:0]               r_out_data, w_out_data_d;
  logic                     r_out_valid, w_out_valid_d;
  logic                     r_out_last, w_out_last_d;
  logic                     r_out_user, w_out_user_d;
  logic [7:0]               r_addr, w_addr_d;
  logic                     r_good, r_bad, r_tout;
  logic                     w_good, w_bad, w_tout;
  logic [TIMEOUT_WIDTH-1:0] r_tcnt, w_tcnt_d, w_tcnt_inc;
  logic                     w_accept, w_out_free, w_tout_hit;
  logic                     w_push, w_push_last, w_push_user;
  logic [7:0]               w_chk_sum;

  assign w_out_free = !r_out_valid || output_axis_tready;
  assign w_accept   = input_axis_tvalid && input_axis_tready;
  assign w_tcnt_inc = r_tcnt + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  assign w_chk_sum  = r_sum + input_axis_tdata;
  // Idle-line abort: only counts cycles with no byte offered, so output stalls never trip it.
  assign w_tout_hit = (r_state != StHunt) && (r_state != StFlush) && !input_axis_tvalid &&
                      (timeout != '0) && (w_tcnt_inc == timeout);

  // Input ready: header states always accept; payload/CHK need room in the output stage.
  always_comb begin
    input_axis_tready = 1'b0;
    case (r_state)
      StHunt, StAddr, StLen: input_axis_tready = 1'b1;
      StPayload, StChk:      input_axis_tready = w_out_free;
      default:               input_axis_tready = 1'b0;
    endcase
  end

  // Next-state, checksum, hold/output staging and timeout counter.
  always_comb begin
    w_state_d      = r_state;
    w_sum_d        = r_sum;
    w_len_d        = r_len;
    w_hold_data_d  = r_hold_data;
    w_hold_valid_d = r_hold_valid;
    w_out_data_d   = r_out_data;
    w_out_valid_d  = r_out_valid;
    w_out_last_d   = r_out_last;
    w_out_user_d   = r_out_user;
    w_addr_d       = r_addr;
    w_tcnt_d       = r_tcnt;
    w_good         = 1'b0;
    w_bad          = 1'b0;
    w_tout         = 1'b0;
    w_push         = 1'b0;
    w_push_last    = 1'b0;
    w_push_user    = 1'b0;

    if (r_out_valid && output_axis_tready) begin
      w_out_valid_d = 1'b0;
      w_out_data_d  = 8'h00;
      w_out_last_d  = 1'b0;
      w_out_user_d  = 1'b0;
    end

    if (r_state == StHunt || w_accept) w_tcnt_d = '0;
    else if (!input_axis_tvalid)       w_tcnt_d = w_tcnt_inc;

    if (w_tout_hit) begin
      w_tout    = 1'b1;
      w_state_d = StHunt;
      if (r_hold_valid) begin
        if (w_out_free) begin
          w_push         = 1'b1;
          w_push_last    = 1'b1;
          w_push_user    = 1'b1;
          w_hold_valid_d = 1'b0;
        end else begin
          w_state_d = StFlush;
        end
      end
    end else begin
      case (r_state)
        StHunt: begin
          if (w_accept && input_axis_tdata == SYNC_BYTE) begin
            w_state_d = StAddr;
            w_sum_d   = 8'h00;
          end
        end
        StAddr: begin
          if (w_accept) begin
            w_addr_d  = input_axis_tdata;
            w_sum_d   = w_chk_sum;
            w_state_d = StLen;
          end
        end
        StLen: begin
          if (w_accept) begin
            w_sum_d   = w_chk_sum;
            w_len_d   = input_axis_tdata;
            w_state_d = (input_axis_tdata == 8'h00) ? StChk : StPayload;
          end
        end
        StPayload: begin
          if (w_accept) begin
            w_sum_d        = w_chk_sum;
            w_push         = r_hold_valid;
            w_hold_data_d  = input_axis_tdata;
            w_hold_valid_d = 1'b1;
            w_len_d        = r_len - 8'd1;
            if (r_len == 8'd1) w_state_d = StChk;
          end
        end
        StChk: begin
          if (w_accept) begin
            w_good         = (w_chk_sum == 8'h00);
            w_bad          = (w_chk_sum != 8'h00);
            w_push         = r_hold_valid;
            w_push_last    = 1'b1;
            w_push_user    = (w_chk_sum != 8'h00);
            w_hold_valid_d = 1'b0;
            w_state_d      = StHunt;
          end
        end
        StFlush: begin
          if (w_out_free) begin
            w_push         = 1'b1;
            w_push_last    = 1'b1;
            w_push_user    = 1'b1;
            w_hold_valid_d = 1'b0;
            w_state_d      = StHunt;
          end
        end
        default: w_state_d = StHunt;
      endcase
    end

    if (w_push) begin
      w_out_valid_d = 1'b1;
      w_out_data_d  = r_hold_data;
      w_out_last_d  = w_push_last;
      w_out_user_d  = w_push_user;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StHunt;
      r_sum        <= 8'h00;
      r_len        <= 8'h00;
      r_hold_data  <= 8'h00;
      r_hold_valid <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_out_user   <= 1'b0;
      r_addr       <= 8'h00;
      r_tcnt       <= '0;
      r_good       <= 1'b0;
      r_bad        <= 1'b0;
      r_tout       <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_sum        <= w_sum_d;
      r_len        <= w_len_d;
      r_hold_data  <= w_hold_data_d;
      r_hold_valid <= w_hold_valid_d;
      r_out_data   <= w_out_data_d;
      r_out_valid  <= w_out_valid_d;
      r_out_last   <= w_out_last_d;
      r_out_user   <= w_out_user_d;
      r_addr       <= w_addr_d;
      r_tcnt       <= w_tcnt_d;
      r_good       <= w_good;
      r_bad        <= w_bad;
      r_tout       <= w_tout;
    end
  end

  assign output_axis_tdata  = r_out_data;
  assign output_axis_tvalid = r_out_valid;
  assign output_axis_tlast  = r_out_last;
  assign output_axis_tuser  = r_out_user;
  assign frame_addr         = r_addr;
  assign frame_good         = r_good;
  assign frame_bad          = r_bad;
  assign timeout_error      = r_tout;
  assign busy               = (r_state != StHunt);

`ifdef UART_FRAME_PARSER_STATS_EN
  logic [15:0] r_frame_cnt, r_err_cnt;

  // Saturating good/error frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt <= 16'h0000;
      r_err_cnt   <= 16'h0000;
    end else begin
      if (w_good && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
      if ((w_bad || w_tout) && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign frame_count = r_frame_cnt;
  assign error_count = r_err_cnt;
`else
  assign frame_count = 16'h0000;
  assign error_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser.
module tb_uart_frame_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  input_axis_tdata = 8'h00;
  logic        input_axis_tvalid = 1'b0;
  logic        input_axis_tready;
  logic [7:0]  output_axis_tdata;
  logic        output_axis_tvalid;
  logic        output_axis_tready = 1'b1;
  logic        output_axis_tlast;
  logic        output_axis_tuser;
  logic [7:0]  frame_addr;
  logic        frame_good, frame_bad, timeout_error, busy;
  logic [15:0] frame_count, error_count;
  logic [15:0] timeout = 16'd0;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state: beats are {user, last, data}.
  logic [9:0] beat_q[$];
  int n_good = 0, n_bad = 0, n_tout = 0, n_stall_drop = 0;
  logic tog_en = 1'b0;

  uart_frame_parser dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (input_axis_tdata),
    .input_axis_tvalid  (input_axis_tvalid),
    .input_axis_tready  (input_axis_tready),
    .output_axis_tdata  (output_axis_tdata),
    .output_axis_tvalid (output_axis_tvalid),
    .output_axis_tready (output_axis_tready),
    .output_axis_tlast  (output_axis_tlast),
    .output_axis_tuser  (output_axis_tuser),
    .frame_addr         (frame_addr),
    .frame_good         (frame_good),
    .frame_bad          (frame_bad),
    .timeout_error      (timeout_error),
    .busy               (busy),
    .frame_count        (frame_count),
    .error_count        (error_count),
    .timeout            (timeout)
  );

  always #5 clk = ~clk;

  // Mid-cycle sampling; inputs only change 1 time unit after posedge.
  always @(negedge clk) begin
    if (output_axis_tvalid && output_axis_tready)
      beat_q.push_back({output_axis_tuser, output_axis_tlast, output_axis_tdata});
    if (frame_good) n_good++;
    if (frame_bad) n_bad++;
    if (timeout_error) n_tout++;
    if (output_axis_tvalid && !output_axis_tready && !input_axis_tready) n_stall_drop++;
  end

  always begin
    @(posedge clk);
    #1;
    if (tog_en) output_axis_tready = ~output_axis_tready;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    beat_q.delete();
    n_good = 0; n_bad = 0; n_tout = 0; n_stall_drop = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    input_axis_tdata  = b;
    input_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!input_axis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_bound", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    input_axis_tvalid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] beat_at(input int i);
    if (i < beat_q.size()) return {22'd0, beat_q[i]};
    return 32'hDEAD;
  endfunction

  // Checks a three-beat 10/20/30 frame with the given tuser on the last beat.
  task automatic check_three(input string tag, input logic user);
    check({tag, "_nbeats"}, beat_q.size(), 32'd3);
    check({tag, "_b0"}, beat_at(0), {22'd0, 2'b00, 8'h10});
    check({tag, "_b1"}, beat_at(1), {22'd0, 2'b00, 8'h20});
    check({tag, "_b2"}, beat_at(2), {22'd0, user, 1'b1, 8'h30});
  endtask

  initial begin
    int n_last;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_tvalid", output_axis_tvalid, 0);
    check("rst_addr", frame_addr, 0);
    check("rst_fcnt", frame_count, 0);
    check("rst_ecnt", error_count, 0);
    check("rst_tready", input_axis_tready, 1);

    // Good three-byte frame.
    clear_mon();
    send_seq('{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9C});
    idle(5);
    check_three("good", 1'b0);
    check("good_pulse", n_good, 1);
    check("good_nobad", n_bad, 0);
    check("good_addr", frame_addr, 8'h01);
    check("good_busy", busy, 0);

    // Bad checksum.
    clear_mon();
    send_seq('{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h00});
    idle(5);
    check_three("bad", 1'b1);
    check("bad_pulse", n_bad, 1);
    check("bad_nogood", n_good, 0);

    // Leading junk, LEN=0.
    clear_mon();
    send_seq('{8'h00, 8'hFF, 8'hA5, 8'h07, 8'h00, 8'hF9});
    idle(5);
    check("len0_nbeats", beat_q.size(), 0);
    check("len0_good", n_good, 1);
    check("len0_addr", frame_addr, 8'h07);

    // Inter-byte timeout with a held payload byte.
    clear_mon();
    timeout = 16'd20;
    send_seq('{8'hA5, 8'h02, 8'h02, 8'h11});
    idle(18);
    check("tout_early", n_tout, 0);
    idle(7);
    check("tout_nbeats", beat_q.size(), 1);
    check("tout_b0", beat_at(0), {22'd0, 2'b11, 8'h11});
    check("tout_pulse", n_tout, 1);
    check("tout_busy", busy, 0);
    check("tout_nogood", n_good + n_bad, 0);
    timeout = 16'd0;

    // Output backpressure toggling.
    clear_mon();
    tog_en = 1'b1;
    send_seq('{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20, 8'h30, 8'h9C});
    idle(10);
    tog_en = 1'b0;
    output_axis_tready = 1'b1;
    idle(3);
    check_three("bp", 1'b0);
    check("bp_good", n_good, 1);
    check("bp_stall_drop", n_stall_drop > 0, 1);

    // Counters: 3 good, 1 bad, 1 timeout so far.
`ifdef UART_FRAME_PARSER_STATS_EN
    check("stats_fcnt", frame_count, 16'd3);
    check("stats_ecnt", error_count, 16'd2);
`else
    check("stats_fcnt", frame_count, 16'd0);
    check("stats_ecnt", error_count, 16'd0);
`endif

    // SYNC value as plain data in every field.
    clear_mon();
    send_seq('{8'hA5, 8'hA5, 8'h01, 8'hA5, 8'hB5});
    idle(5);
    check("syncdata_nbeats", beat_q.size(), 1);
    check("syncdata_b0", beat_at(0), {22'd0, 2'b01, 8'hA5});
    check("syncdata_good", n_good, 1);
    check("syncdata_addr", frame_addr, 8'hA5);

    // Reset mid-payload drops the frame with no tlast.
    clear_mon();
    send_seq('{8'hA5, 8'h01, 8'h03, 8'h10, 8'h20});
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_tvalid", output_axis_tvalid, 0);
    check("midrst_addr", frame_addr, 0);
    check("midrst_fcnt", frame_count, 0);
    check("midrst_ecnt", error_count, 0);
    idle(5);
    n_last = 0;
    foreach (beat_q[i]) if (beat_q[i][8]) n_last++;
    check("midrst_nolast", n_last, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
